// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and helpers. The AES-128 cipher core and
// the key-schedule block both import this package.
//   byte_t / word_t / state_t / rk_idx_t : 8 / 32 / 128 / 4-bit types
//   NR                                   : number of AES-128 rounds
//   rcon()                               : round constant for rounds 1..10
//   rot_word()                           : FIPS RotWord
//   get_word() / put_word()              : convert a column c between the
//                                          row-major 128-bit state and a
//                                          FIPS word
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;
  typedef logic [3:0]   rk_idx_t;

  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_EXPAND = 2'd1,
    KS_DONE   = 2'd2
  } ks_state_t;

  localparam int NR = 10;

  function automatic byte_t rcon(input rk_idx_t i);
    byte_t r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  // byte(r,c) sits at bits [127-8*(4r+c) -: 8]; the word holds row 0 in its MSBs.
  function automatic word_t get_word(input state_t s, input int c);
    word_t w;
    w = '0;
    for (int r = 0; r < 4; r++) begin
      w[31-8*r -: 8] = s[127-8*(4*r+c) -: 8];
    end
    return w;
  endfunction

  function automatic state_t put_word(input state_t s, input int c, input word_t w);
    state_t t;
    t = s;
    for (int r = 0; r < 4; r++) begin
      t[127-8*(4*r+c) -: 8] = w[31-8*r -: 8];
    end
    return t;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box (also used by the cipher core's SubBytes).
//   byte_val : input byte
//   sub_val  : S-box substitution of byte_val
module aes_sbox
  import aes_pkg::*;
(
  input  byte_t byte_val,
  output byte_t sub_val
);

  // Entry 0 occupies the MSBs, so entry x starts at bit 2047-8x = {~x, 3'b111}.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign sub_val = SBOX_TBL[{~byte_val, 3'b111} -: 8];

endmodule

// File: rtl/aes128_key_expand.sv
// Iterative AES-128 key schedule feeding the AES-128 cipher core.
// A key accepted over key_valid/key_ready is expanded at one round key per
// clock into an 11-entry register file that the core reads by index
// (ascending for encrypt, descending for decrypt).
//   clk, reset  : clock, asynchronous active-high reset
//   key_in      : 128-bit cipher key, row-major packing (row 0 in MSBs)
//   key_valid   : key_in valid
//   key_ready   : key can be accepted (IDLE or DONE)
//   rk_rd_idx   : round-key read index 0..10; 11..15 read as zero
//   rk_rd_data  : round key[rk_rd_idx], combinational
//   keys_valid  : all 11 round keys stored and stable
//   busy        : expansion in progress
module aes128_key_expand
  import aes_pkg::*;
#(
  parameter int NR     = 10,
  parameter int N_SBOX = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  state_t  key_in,
  input  logic    key_valid,
  output logic    key_ready,
  input  rk_idx_t rk_rd_idx,
  output state_t  rk_rd_data,
  output logic    keys_valid,
  output logic    busy
);

  if (NR != 10) begin : g_bad_nr
    $error("aes128_key_expand: NR must be 10 for AES-128");
  end
  if (N_SBOX != 4) begin : g_bad_nsbox
    $error("aes128_key_expand: N_SBOX must be 4 (one SubWord per cycle)");
  end

  localparam rk_idx_t LAST = rk_idx_t'(NR);

  ks_state_t fsm;
  rk_idx_t   round;
  state_t    work;
  state_t    rk [0:NR];

  word_t  rot;
  word_t  sub;
  state_t next_key;
  logic   accept;

  assign accept = key_valid && key_ready;

  // SubWord(RotWord(w3)): one S-box per byte of the rotated last column.
  assign rot = rot_word(get_word(work, 3));

  for (genvar gi = 0; gi < N_SBOX; gi++) begin : g_sbox
    aes_sbox u_sbox (
      .byte_val (rot[31-8*gi -: 8]),
      .sub_val  (sub[31-8*gi -: 8])
    );
  end

  always_comb begin
    word_t w0, w1, w2, w3;
    next_key = '0;
    w0 = get_word(work, 0) ^ sub ^ {rcon(round), 24'h000000};
    w1 = get_word(work, 1) ^ w0;
    w2 = get_word(work, 2) ^ w1;
    w3 = get_word(work, 3) ^ w2;
    next_key = put_word(next_key, 0, w0);
    next_key = put_word(next_key, 1, w1);
    next_key = put_word(next_key, 2, w2);
    next_key = put_word(next_key, 3, w3);
  end

  // Reset also zeroizes the key material so an aborted expansion leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm        <= KS_IDLE;
      round      <= '0;
      work       <= '0;
      key_ready  <= 1'b0;
      keys_valid <= 1'b0;
      busy       <= 1'b0;
      for (int i = 0; i <= NR; i++) begin
        rk[i] <= '0;
      end
    end else begin
      case (fsm)
        KS_IDLE, KS_DONE: begin
          if (accept) begin
            rk[0]      <= key_in;
            work       <= key_in;
            round      <= 4'd1;
            fsm        <= KS_EXPAND;
            key_ready  <= 1'b0;
            keys_valid <= 1'b0;
            busy       <= 1'b1;
          end else begin
            key_ready  <= 1'b1;
          end
        end
        KS_EXPAND: begin
          rk[round] <= next_key;
          work      <= next_key;
          round     <= round + 4'd1;
          if (round == LAST) begin
            fsm        <= KS_DONE;
            busy       <= 1'b0;
            keys_valid <= 1'b1;
            key_ready  <= 1'b1;
          end
        end
        default: begin
          fsm <= KS_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rk_rd_data = '0;
    if (rk_rd_idx <= LAST) begin
      rk_rd_data = rk[rk_rd_idx];
    end
  end

endmodule

// File: tb/tb_aes128_key_expand.sv
// Self-checking bench for aes128_key_expand. Expected round keys come from an
// independent key-schedule model (S-box derived from the GF(2^8) inverse and
// affine map) and are queued when a key is driven, then popped as the DUT's
// register file is read back.
module tb_aes128_key_expand;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [3:0]   rk_rd_idx;
  logic [127:0] rk_rd_data;
  logic         keys_valid;
  logic         busy;

  int checks = 0;
  int failures = 0;

  logic [127:0] exp_q [$];
  logic [127:0] mrk [0:10];

  localparam logic [127:0] ONE  = 128'd1;
  localparam logic [127:0] ZERO = 128'd0;
  localparam logic [127:0] FIPS_KEY = 128'h2B28AB097EAEF7CF15D2154F16A6883C;
  localparam logic [127:0] FIPS_RK1 = 128'hA088232AFA54A36CFE2C397617B13905;
  localparam logic [127:0] FIPS_RK10 = 128'hD0C9E1B614EE3F63F9250C0CA889C8A6;
  localparam logic [127:0] ZERO_RK1 = 128'h62626262636363636363636363636363;

  always #20 clk = ~clk;

  aes128_key_expand dut (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .rk_rd_idx  (rk_rd_idx),
    .rk_rd_data (rk_rd_data),
    .keys_valid (keys_valid),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] x);
    logic [7:0] inv, s;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  task automatic compute_model(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int c = 0; c < 4; c++) begin
      w[c] = {key[127-8*c -: 8], key[95-8*c -: 8], key[63-8*c -: 8], key[31-8*c -: 8]};
    end
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m(t[31:24]), sbox_m(t[23:16]), sbox_m(t[15:8]), sbox_m(t[7:0])};
        t[31:24] = t[31:24] ^ rc;
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 11; j++) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          mrk[j][127-32*r-8*c -: 8] = w[4*j+c][31-8*r -: 8];
        end
      end
    end
  endtask

  task automatic push_expected(input bit desc);
    for (int k = 0; k < 11; k++) begin
      exp_q.push_back(mrk[desc ? 10 - k : k]);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [127:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check(tag, rk_rd_data, e);
  endtask

  // Reads the whole file inside one clock period.
  task automatic sweep(input string tag);
    for (int k = 0; k < 11; k++) begin
      rk_rd_idx = 4'(k);
      #1;
      pop_check($sformatf("%s_rk%0d", tag, k));
    end
  endtask

  task automatic load(input logic [127:0] k);
    compute_model(k);
    push_expected(1'b0);
    key_in = k;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit chk_ctl, output int cyc);
    cyc = 0;
    while (!keys_valid && cyc < 40) begin
      if (chk_ctl) begin
        check($sformatf("%s_busy_c%0d", tag, cyc), 128'(busy), ONE);
        check($sformatf("%s_rdy_c%0d", tag, cyc), 128'(key_ready), ZERO);
      end
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("%s_latency", tag), 128'(cyc), 128'(10));
  endtask

  initial begin
    int cyc;
    logic [127:0] k3, k4, k5, k6;
    key_valid = 1'b0;
    key_in = '0;
    rk_rd_idx = '0;

    #2 reset = 1'b1;
    #3;
    check("rst_key_ready", 128'(key_ready), ZERO);
    check("rst_keys_valid", 128'(keys_valid), ZERO);
    check("rst_busy", 128'(busy), ZERO);
    check("rst_rk0", rk_rd_data, ZERO);
    repeat (2) @(posedge clk);
    #5 reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", 128'(key_ready), ONE);
    check("post_rst_kv", 128'(keys_valid), ZERO);

    // FIPS-197 Appendix A key
    load(FIPS_KEY);
    check("fips_kv_low", 128'(keys_valid), ZERO);
    wait_done("fips", 1'b1, cyc);
    check("fips_done_busy", 128'(busy), ZERO);
    check("fips_done_ready", 128'(key_ready), ONE);
    sweep("fips");
    rk_rd_idx = 4'd1;  #1; check("fips_rk1_const", rk_rd_data, FIPS_RK1);
    rk_rd_idx = 4'd10; #1; check("fips_rk10_const", rk_rd_data, FIPS_RK10);
    rk_rd_idx = 4'd0;  #1; check("fips_rk0_key", rk_rd_data, FIPS_KEY);

    // key_valid held through EXPAND with a different key
    k3 = {$urandom, $urandom, $urandom, $urandom};
    k4 = {$urandom, $urandom, $urandom, $urandom};
    compute_model(k3);
    push_expected(1'b0);
    key_in = k3;
    key_valid = 1'b1;
    @(posedge clk); #1;
    check("reload_kv_drop", 128'(keys_valid), ZERO);
    key_in = k4;
    wait_done("held1", 1'b1, cyc);
    sweep("held1");
    compute_model(k4);
    push_expected(1'b0);
    @(posedge clk); #1;
    key_valid = 1'b0;
    check("held2_busy", 128'(busy), ONE);
    check("held2_kv", 128'(keys_valid), ZERO);
    wait_done("held2", 1'b0, cyc);
    sweep("held2");

    // Reset during round 5
    k5 = {$urandom, $urandom, $urandom, $urandom};
    key_in = k5;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_busy_pre", 128'(busy), ONE);
    reset = 1'b1;
    #1;
    check("abort_ready", 128'(key_ready), ZERO);
    check("abort_kv", 128'(keys_valid), ZERO);
    check("abort_busy", 128'(busy), ZERO);
    for (int k = 0; k < 11; k++) exp_q.push_back(ZERO);
    sweep("abort");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_ready_back", 128'(key_ready), ONE);
    k6 = {$urandom, $urandom, $urandom, $urandom};
    load(k6);
    wait_done("fresh", 1'b1, cyc);
    sweep("fresh");

    // All-zero key
    load(ZERO);
    wait_done("zero", 1'b0, cyc);
    sweep("zero");
    rk_rd_idx = 4'd1;  #1; check("zero_rk1_const", rk_rd_data, ZERO_RK1);
    rk_rd_idx = 4'd11; #1; check("idx11_zero", rk_rd_data, ZERO);
    rk_rd_idx = 4'd15; #1; check("idx15_zero", rk_rd_data, ZERO);

    // Decrypt-order sweep, one index per cycle, on a re-expanded FIPS key
    compute_model(FIPS_KEY);
    push_expected(1'b1);
    key_in = FIPS_KEY;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    wait_done("dec", 1'b0, cyc);
    for (int k = 0; k < 11; k++) begin
      rk_rd_idx = 4'(10 - k);
      #1;
      pop_check($sformatf("dec_rk%0d", 10 - k));
      check($sformatf("dec_kv%0d", 10 - k), 128'(keys_valid), ONE);
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    rk_rd_idx = 4'd10; #1; check("dec_stable_rk10", rk_rd_data, mrk[10]);
    rk_rd_idx = 4'd5;  #1; check("dec_stable_rk5", rk_rd_data, mrk[5]);
    check("sb_drained", 128'(exp_q.size()), ZERO);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
